// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI responder bundle: pad pins plus local TX/RX side.
// Optional err_cnt/err_clr signals appear when SPI_SLAVE_ERR_CNT_EN is defined.
`timescale 1ns/1ps
interface spi_slave_if #(parameter int DATA_W = 8);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              underrun;
  logic              frame_err;
`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0]        err_cnt;
  logic              err_clr;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid, err_clr,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun, frame_err, err_cnt
  );
  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid, err_clr,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun, frame_err, err_cnt
  );
`else
  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun, frame_err
  );
  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun, frame_err
  );
`endif
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI mode-0 responder with one-entry TX holding buffer.
// Define SPI_SLAVE_ERR_CNT_EN to add the saturating err_cnt counter with err_clr.
`timescale 1ns/1ps
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_slave_if.slave  bus
);
  localparam int              CNT_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, cs_hist_q;

  state_t            state_q;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full_q;
  logic [DATA_W-1:0] shift_tx_q;
  logic [DATA_W-2:0] shift_rx_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              word_bnd_q;
  logic              miso_q, miso_oe_q, busy_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q, underrun_q, frame_err_q;

  logic              sclk_s, cs_s, mosi_s;
  logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic              load_req, tx_wr;
  logic [DATA_W-1:0] load_word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;

  // A chip-select rise suppresses any sclk edge seen in the same cycle.
  assign load_req    = ((state_q == IDLE) && cs_fall) ||
                       ((state_q == ACTIVE) && !cs_rise && sclk_fall && word_bnd_q);
  assign tx_wr       = bus.tx_valid && !buf_full_q;
  assign load_word_d = buf_full_q ? buf_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      bit_cnt_q   <= CNT_TOP;
      word_bnd_q  <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;

      // A load that coincides with a write sees the buffer empty; the write then refills it.
      if (tx_wr) begin
        buf_q      <= bus.tx_data;
        buf_full_q <= 1'b1;
      end else if (load_req) begin
        buf_full_q <= 1'b0;
      end

      if (load_req) begin
        shift_tx_q <= load_word_d;
        miso_q     <= load_word_d[DATA_W-1];
        underrun_q <= !buf_full_q;
      end

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q    <= ACTIVE;
            bit_cnt_q  <= CNT_TOP;
            word_bnd_q <= 1'b0;
            busy_q     <= 1'b1;
            miso_oe_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            frame_err_q <= (bit_cnt_q != CNT_TOP);
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            word_bnd_q  <= 1'b0;
          end else if (sclk_rise) begin
            shift_rx_q <= {shift_rx_q[DATA_W-3:0], mosi_s};
            if (bit_cnt_q == '0) begin
              rx_data_q  <= {shift_rx_q, mosi_s};
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= CNT_TOP;
              word_bnd_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q - 1'b1;
            end
          end else if (sclk_fall) begin
            if (word_bnd_q) begin
              word_bnd_q <= 1'b0;
            end else begin
              shift_tx_q <= shift_tx_q << 1;
              miso_q     <= shift_tx_q[DATA_W-2];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.miso      = miso_q;
  assign bus.miso_oe   = miso_oe_q;
  assign bus.tx_ready  = ~buf_full_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = busy_q;
  assign bus.underrun  = underrun_q;
  assign bus.frame_err = frame_err_q;

`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic [8:0] err_sum_d;

  // Counts the registered pulses, so the counter trails each pulse by one cycle.
  assign err_sum_d = {1'b0, err_cnt_q} + {8'd0, underrun_q} + {8'd0, frame_err_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_cnt_q <= '0;
    end else if (err_sum_d[8]) begin
      err_cnt_q <= 8'hFF;
    end else begin
      err_cnt_q <= err_sum_d[7:0];
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized SPI master driving spi_slave, checked against a word-level model.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int DW   = 8;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_slave_if #(.DATA_W(DW)) bus ();

  spi_slave #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observed pulse activity
  int              un_cnt = 0;
  int              fe_cnt = 0;
  logic [DW-1:0]   rx_seen[$];

  // Word-level reference model
  logic            m_full = 1'b0;
  logic [DW-1:0]   m_buf  = '0;
  logic [DW-1:0]   m_rx   = '0;
  int              e_un   = 0;
  int              e_fe   = 0;
  int              e_err  = 0;
  logic [DW-1:0]   e_rx[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid)  rx_seen.push_back(bus.rx_data);
      if (bus.underrun)  un_cnt++;
      if (bus.frame_err) fe_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_tx(input logic [DW-1:0] v);
    check("tx_ready_before_write", bus.tx_ready, 1);
    bus.tx_data  = v;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    m_buf  = v;
    m_full = 1'b1;
  endtask

  task automatic take_word(output logic [DW-1:0] w);
    if (m_full) begin
      w      = m_buf;
      m_full = 1'b0;
    end else begin
      w = '0;
      e_un++;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_miso",      bus.miso,      0);
    check("rst_miso_oe",   bus.miso_oe,   0);
    check("rst_tx_ready",  bus.tx_ready,  1);
    check("rst_rx_data",   bus.rx_data,   0);
    check("rst_rx_valid",  bus.rx_valid,  0);
    check("rst_busy",      bus.busy,      0);
    check("rst_underrun",  bus.underrun,  0);
    check("rst_frame_err", bus.frame_err, 0);
`ifdef SPI_SLAVE_ERR_CNT_EN
    check("rst_err_cnt",   bus.err_cnt,   0);
`endif
  endtask

  // nw full words then an aborted word of 'part' bits (0 = no abort)
  task automatic run_frame(input int nw, input int part, input logic [DW-1:0] mw [4],
                           input logic [3:0] refill, input logic [DW-1:0] rv [4]);
    logic [DW-1:0] cur, got;
    int nb, rx0, un0, fe0, d;
    rx0 = e_rx.size();
    un0 = e_un;
    fe0 = e_fe;
    bus.cs_n = 1'b0;
    take_word(cur);
    for (int w = 0; w <= nw; w++) begin
      nb  = (w < nw) ? DW : part;
      got = '0;
      for (int b = 0; b < nb; b++) begin
        bus.mosi = mw[w][DW-1-b];
        tick(HALF);
        got = {got[DW-2:0], bus.miso};
        bus.sclk = 1'b1;
        tick(HALF);
        if (b == 2 && w < nw) begin
          check("busy_active", bus.busy, 1);
          check("miso_oe_active", bus.miso_oe, 1);
          check("tx_ready_mid", bus.tx_ready, !m_full);
          if (refill[w] && !m_full) write_tx(rv[w]);
        end
        bus.sclk = 1'b0;
      end
      if (w < nw) begin
        check("miso_word", got, cur);
        e_rx.push_back(mw[w]);
        m_rx = mw[w];
        take_word(cur);
      end
    end
    if (part > 0) e_fe++;
    tick(HALF);
    bus.cs_n = 1'b1;
    tick(8);
    check("underrun_count", un_cnt, e_un);
    check("frame_err_count", fe_cnt, e_fe);
    check("rx_count", rx_seen.size(), e_rx.size());
    for (int i = rx0; i < e_rx.size() && i < rx_seen.size(); i++)
      check("rx_word", rx_seen[i], e_rx[i]);
    check("rx_data_hold", bus.rx_data, m_rx);
    check("busy_idle", bus.busy, 0);
    check("miso_oe_idle", bus.miso_oe, 0);
    check("tx_ready_idle", bus.tx_ready, !m_full);
    d = (e_un - un0) + (e_fe - fe0);
    e_err = (e_err + d > 255) ? 255 : e_err + d;
`ifdef SPI_SLAVE_ERR_CNT_EN
    check("err_cnt", bus.err_cnt, e_err);
`endif
  endtask

  initial begin
    logic [DW-1:0] mw [4];
    logic [DW-1:0] rv [4];
    logic [DW-1:0] junk;
    int nw, part, un_base, fe_base, rx_base;

    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
`ifdef SPI_SLAVE_ERR_CNT_EN
    bus.err_clr = 1'b0;
`endif
    tick(4);
    check_reset_vals();
    rst_n = 1'b1;
    tick(10);

    // Single word
    write_tx(8'hA5);
    mw = '{8'h3C, 8'h00, 8'h00, 8'h00};
    rv = '{8'h5A, 8'h00, 8'h00, 8'h00};
    run_frame(1, 0, mw, 4'b0001, rv);

    // Back-to-back words in one frame
    write_tx(8'h11);
    mw = '{8'h81, 8'h7E, 8'h00, 8'h00};
    rv = '{8'h22, 8'h33, 8'h00, 8'h00};
    run_frame(2, 0, mw, 4'b0011, rv);

    // Underrun at frame start
    mw = '{8'hFF, 8'h00, 8'h00, 8'h00};
    rv = '{8'h44, 8'h00, 8'h00, 8'h00};
    run_frame(1, 0, mw, 4'b0001, rv);

    // Abort after 5 bits, then a normal frame
    mw = '{8'hC3, 8'h00, 8'h00, 8'h00};
    run_frame(0, 5, mw, 4'b0000, rv);
    write_tx(8'h96);
    mw = '{8'h69, 8'h00, 8'h00, 8'h00};
    rv = '{8'h0F, 8'h00, 8'h00, 8'h00};
    run_frame(1, 0, mw, 4'b0001, rv);

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      nw   = $urandom_range(0, 3);
      part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW - 1) : 0;
      if (nw == 0 && part == 0) nw = 1;
      for (int i = 0; i < 4; i++) begin
        mw[i] = DW'($urandom);
        rv[i] = DW'($urandom);
      end
      if (!m_full && $urandom_range(0, 1) == 1) write_tx(DW'($urandom));
      run_frame(nw, part, mw, 4'($urandom), rv);
    end

`ifdef SPI_SLAVE_ERR_CNT_EN
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    e_err = 0;
    check("err_clr", bus.err_cnt, 0);
    for (int i = 0; i < 150; i++) begin
      mw = '{8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(0, 1, mw, 4'b0000, rv);
    end
    check("err_cnt_saturated", bus.err_cnt, 255);
`endif

    // Reset asserted mid-frame with sclk toggling
    bus.cs_n = 1'b0;
    take_word(junk);
    tick(HALF);
    for (int i = 0; i < 3; i++) begin
      bus.sclk = 1'b1; tick(HALF);
      bus.sclk = 1'b0; tick(HALF);
    end
    bus.sclk = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    bus.sclk = 1'b0;
    tick(2);
    check_reset_vals();
    bus.cs_n = 1'b1;
    tick(3);
    m_full = 1'b0;
    m_rx   = '0;
    e_err  = 0;
    un_base = e_un;
    fe_base = e_fe;
    rx_base = e_rx.size();
    rst_n = 1'b1;
    tick(20);
    check("idle_underrun", un_cnt, un_base);
    check("idle_frame_err", fe_cnt, fe_base);
    check("idle_rx_valid", rx_seen.size(), rx_base);
    check("idle_tx_ready", bus.tx_ready, 1);
    check("idle_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) that serves an external SPI master.
- SCLK, CS_N and MOSI are oversampled in the system clock domain; no logic is clocked by SCLK.
- Exchanges DATA_W-bit words full-duplex: receives words on MOSI and returns words from a one-entry TX holding buffer on MISO.
- Sits between the pad-level SPI pins and the local register/command logic.

Parameters:
DATA_W, 8, word width in bits (legal range 4..32)
SYNC_STAGES, 2, synchronizer flops on sclk/cs_n/mosi (minimum 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock from master, asynchronous to clk
cs_n  input  1  SPI chip select, active low, asynchronous
mosi  input  1  SPI data from master
miso  output  1  SPI data to master
miso_oe  output  1  MISO output enable (1 while selected)
tx_data  input  DATA_W  next word to return to master
tx_valid  input  1  tx_data valid
tx_ready  output  1  TX holding buffer empty
rx_data  output  DATA_W  last received word
rx_valid  output  1  one-cycle pulse: rx_data updated
busy  output  1  frame in progress (synced cs_n low)
underrun  output  1  one-cycle pulse: word started with TX buffer empty
frame_err  output  1  one-cycle pulse: cs_n rose mid-word

Behaviour:
- Reset is asynchronous and active-low (rst_n); clock is clk; there is a single clock domain.
- Reset values:
  - Outputs: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0, frame_err=0.
  - Internal: sync chains reset to sclk=0, cs_n=1, mosi=0; TX buffer empty; state IDLE.
- Input timing requirements: sclk high and low each ≥3 clk cycles; cs_n fall to first sclk rise ≥4 clk; last sclk fall to cs_n rise ≥4 clk.
- Edge detection: a rise or fall of synced sclk is detected by comparing the last sync stage with one extra history flop. Input-to-detect latency is SYNC_STAGES+1 clk.
- TX holding buffer:
  - tx_ready = buffer empty. tx_valid && tx_ready latches tx_data and sets the buffer full.
  - A word load empties the buffer. If a load and a write occur in the same cycle with the buffer empty, the load sees empty and the write fills the buffer.
- State machine IDLE -> ACTIVE:
  - IDLE: busy=0, miso_oe=0. On synced cs_n fall: go to ACTIVE, do a word load, set bit_cnt=DATA_W-1, set busy=1 and miso_oe=1.
  - Word load: shift_tx <= buffer if full, else 0 with a one-cycle underrun pulse. miso <= MSB of the loaded word in the same cycle, so it is valid before the first sclk rise.
  - ACTIVE, sclk rise: shift_rx <= {shift_rx[DATA_W-2:0], mosi_synced}.
    - If bit_cnt==0: rx_data <= completed word, rx_valid=1 for one cycle, bit_cnt <= DATA_W-1, set word_boundary.
    - Else: bit_cnt decrements.
  - ACTIVE, sclk fall: if word_boundary, do a word load and clear word_boundary. Else shift_tx left by one and miso <= new MSB.
  - ACTIVE, synced cs_n rise:
    - If bit_cnt != DATA_W-1, the partial word is discarded (rx_data unchanged, no rx_valid) and frame_err pulses for one cycle.
    - In all cases: go to IDLE, miso_oe=0, busy=0, clear word_boundary. miso holds its value.
  - Simultaneous cs_n rise and sclk edge in the same clk: the cs_n rise wins and the sclk edge is ignored.
- Multiple words per frame are back-to-back with no gap; each word boundary reloads from the TX buffer.
- rx_valid has no back-pressure: a new word overwrites rx_data.

Optional Feature:
- Macro SPI_SLAVE_ERR_CNT_EN.
- Defined: adds output err_cnt [7:0], reset 0. It increments (saturating at 255) on each underrun or frame_err pulse; both pulses in the same cycle add 2, still saturating at 255. Input err_clr (1 bit) synchronously zeroes it; err_clr has priority over increment.
- Undefined: no err_cnt or err_clr ports, no counter logic; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-frame with sclk toggling -> all outputs at reset values, tx_ready=1; after release, idle cs_n=1 gives no pulses.
- Single word: preload tx_data=0xA5, master sends 0x3C over 8 sclk -> master receives 0xA5, rx_data=0x3C with one rx_valid pulse, tx_ready=1 after load, no underrun or frame_err.
- Back-to-back: preload 0x11, refill 0x22 during first word, master sends 0x81,0x7E in one frame -> master receives 0x11,0x22; two rx_valid pulses with 0x81 then 0x7E.
- Underrun: buffer empty at cs_n fall, master sends 0xFF -> master receives 0x00, one underrun pulse, rx_data=0xFF.
- Abort: cs_n rises after 5 sclk rises -> frame_err pulse, no rx_valid, rx_data keeps previous value, busy=0, miso_oe=0; the next full frame works normally.
- With SPI_SLAVE_ERR_CNT_EN: 3 underruns + 1 abort -> err_cnt=4; err_clr -> 0; 300 errors -> saturates at 255.
